// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access unit: access-type and exception
// codes, FSM state encoding and byte-lane helpers.
package mem_access_pkg;

  localparam logic [2:0] MT_W  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_HU = 3'b010;
  localparam logic [2:0] MT_B  = 3'b011;
  localparam logic [2:0] MT_BU = 3'b100;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } mau_state_e;

  function automatic logic type_reserved(input logic [2:0] mem_type);
    return (mem_type > MT_BU);
  endfunction

  function automatic logic misaligned(input logic [2:0] mem_type, input logic [1:0] offset);
    logic mis;
    case (mem_type)
      MT_W:        mis = (offset != 2'b00);
      MT_H, MT_HU: mis = offset[0];
      default:     mis = 1'b0;
    endcase
    return mis;
  endfunction

  // Byte lanes of a store; the memory itself does the data shift.
  function automatic logic [3:0] be_pattern(input logic [2:0] mem_type, input logic [1:0] offset);
    logic [3:0] be;
    case (mem_type)
      MT_W:        be = 4'b1111;
      MT_H, MT_HU: be = offset[1] ? 4'b1100 : 4'b0011;
      MT_B, MT_BU: be = 4'b0001 << offset;
      default:     be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake from the MEM stage plus the DM word port.
// master: the access unit (initiator toward DM); slave: pipeline + memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] req_pc;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [4:0]  resp_exc_code;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wd;
  logic [31:0] mem_wpc;
  logic [31:0] mem_rd;

  modport master (
    input  req_valid, req_write, req_type, req_addr, req_wdata, req_pc, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code,
           mem_addr, mem_be, mem_wd, mem_wpc
  );

  modport slave (
    output req_valid, req_write, req_type, req_addr, req_wdata, req_pc, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_exc, resp_exc_code,
           mem_addr, mem_be, mem_wd, mem_wpc
  );
endinterface

// File: rtl/mem_access_unit_load_extend.sv
// Picks the addressed byte/half out of a read word and sign- or zero-extends it.
// Purely combinational so a future cache can reuse it on its own data path.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  mem_type,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (offset)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];

    case (mem_type)
      MT_H:    data = {{16{half_sel[15]}}, half_sel};
      MT_HU:   data = {16'h0000, half_sel};
      MT_B:    data = {{24{byte_sel[7]}}, byte_sel};
      MT_BU:   data = {24'h000000, byte_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: one load/store at a time, alignment/range checks,
// byte-enable generation and load extraction over a configurable-latency DM port.
//
//   state | meaning
//   IDLE  | ready for a request; checks it on acceptance
//   ISSUE | address/PC driven, store byte enables asserted for this cycle only
//   WAIT  | address held, enables low, counting down the read latency
//   RESP  | one-cycle response pulse (data or exception)
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DM_WORDS    = 2048,
  parameter int MEM_LATENCY = 1
) (
  input  logic               Clock1,
  input  logic               Reset,
  input  logic               flush,
  mem_access_unit_if.master  bus
);

  // WAIT lasts MEM_LATENCY-1 cycles; the counter reaches zero on the capture cycle.
  localparam logic [2:0] WAIT_INIT = 3'(MEM_LATENCY > 1 ? MEM_LATENCY - 2 : 0);

  mau_state_e  state;
  logic [2:0]  wait_cnt;
  logic [2:0]  lat_type;
  logic        lat_write;
  logic        ready_r;
  logic [31:0] addr_r;
  logic [31:0] wd_r;
  logic [31:0] wpc_r;
  logic [3:0]  be_r;
  logic        resp_valid_r;
  logic [31:0] rdata_r;
  logic        exc_r;
  logic [4:0]  code_r;

  logic        accept;
  logic        req_exc;
  logic        req_reserved;
  logic        req_out_of_range;
  logic [4:0]  req_code;
  logic [31:0] ext_data;
  logic [31:0] cap_data;
  logic        resp_live;

  always_comb begin
    req_reserved     = type_reserved(bus.req_type);
    req_out_of_range = ({2'b00, bus.req_addr[31:2]} >= 32'(DM_WORDS));
    req_exc          = req_reserved
                     | misaligned(bus.req_type, bus.req_addr[1:0])
                     | req_out_of_range;
    if (req_reserved)       req_code = EXC_RI;
    else if (bus.req_write) req_code = EXC_ADES;
    else                    req_code = EXC_ADEL;
    accept = (state == IDLE) & bus.req_valid & ~flush;
  end

  load_extend u_load_extend (
    .word     (bus.mem_rd),
    .offset   (addr_r[1:0]),
    .mem_type (lat_type),
    .data     (ext_data)
  );

  assign cap_data = lat_write ? 32'h0 : ext_data;

  always_ff @(posedge Clock1) begin
    if (Reset) begin
      state        <= IDLE;
      wait_cnt     <= 3'd0;
      lat_type     <= 3'd0;
      lat_write    <= 1'b0;
      ready_r      <= 1'b1;
      addr_r       <= 32'h0;
      wd_r         <= 32'h0;
      wpc_r        <= 32'h0;
      be_r         <= 4'b0000;
      resp_valid_r <= 1'b0;
      rdata_r      <= 32'h0;
      exc_r        <= 1'b0;
      code_r       <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready_r   <= 1'b0;
            lat_type  <= bus.req_type;
            lat_write <= bus.req_write;
            if (req_exc) begin
              state        <= RESP;
              resp_valid_r <= 1'b1;
              rdata_r      <= 32'h0;
              exc_r        <= 1'b1;
              code_r       <= req_code;
            end else begin
              state    <= ISSUE;
              addr_r   <= bus.req_addr;
              wpc_r    <= bus.req_pc;
              be_r     <= bus.req_write ? be_pattern(bus.req_type, bus.req_addr[1:0]) : 4'b0000;
              wd_r     <= bus.req_write ? bus.req_wdata : 32'h0;
              wait_cnt <= WAIT_INIT;
            end
          end
        end

        ISSUE: begin
          be_r <= 4'b0000;
          wd_r <= 32'h0;
          if (flush) begin
            state   <= IDLE;
            ready_r <= 1'b1;
            addr_r  <= 32'h0;
            wpc_r   <= 32'h0;
          end else if (MEM_LATENCY == 1) begin
            state        <= RESP;
            resp_valid_r <= 1'b1;
            rdata_r      <= cap_data;
            exc_r        <= 1'b0;
            code_r       <= 5'd0;
            addr_r       <= 32'h0;
            wpc_r        <= 32'h0;
          end else begin
            state <= WAIT;
          end
        end

        WAIT: begin
          if (flush) begin
            state   <= IDLE;
            ready_r <= 1'b1;
            addr_r  <= 32'h0;
            wpc_r   <= 32'h0;
          end else if (wait_cnt == 3'd0) begin
            state        <= RESP;
            resp_valid_r <= 1'b1;
            rdata_r      <= cap_data;
            exc_r        <= 1'b0;
            code_r       <= 5'd0;
            addr_r       <= 32'h0;
            wpc_r        <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt - 3'd1;
          end
        end

        RESP: begin
          state        <= IDLE;
          ready_r      <= 1'b1;
          resp_valid_r <= 1'b0;
          rdata_r      <= 32'h0;
          exc_r        <= 1'b0;
          code_r       <= 5'd0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // A late flush or Reset must still cancel a store and a pending response this cycle.
  assign resp_live         = resp_valid_r & ~flush & ~Reset;
  assign bus.req_ready     = ready_r & ~flush;
  assign bus.mem_be        = be_r & {4{~(flush | Reset)}};
  assign bus.mem_addr      = addr_r;
  assign bus.mem_wd        = wd_r;
  assign bus.mem_wpc       = wpc_r;
  assign bus.resp_valid    = resp_live;
  assign bus.resp_rdata    = resp_live ? rdata_r : 32'h0;
  assign bus.resp_exc      = resp_live & exc_r;
  assign bus.resp_exc_code = resp_live ? code_r : 5'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: a latency-1 unit on a byte-lane memory model and a latency-3
// unit reading the same memory through a two-stage address pipeline.
module tb_mem_access_unit;
  import mem_access_pkg::*;

  logic Clock1 = 1'b0;
  logic Reset;
  logic flush1;
  logic flush3;

  always #5 Clock1 = ~Clock1;

  mem_access_unit_if bus1();
  mem_access_unit_if bus3();

  mem_access_unit #(.DM_WORDS(2048), .MEM_LATENCY(1)) u_dut (
    .Clock1 (Clock1),
    .Reset  (Reset),
    .flush  (flush1),
    .bus    (bus1)
  );

  mem_access_unit #(.DM_WORDS(2048), .MEM_LATENCY(3)) u_dut3 (
    .Clock1 (Clock1),
    .Reset  (Reset),
    .flush  (flush3),
    .bus    (bus3)
  );

  logic [31:0] dm [0:2047];
  logic [31:0] wshift;
  logic [31:0] wmask;
  logic [31:0] addr_d1;
  logic [31:0] addr_d2;
  int          wr_count = 0;

  assign wshift = bus1.mem_wd << {bus1.mem_addr[1:0], 3'b000};
  assign wmask  = {{8{bus1.mem_be[3]}}, {8{bus1.mem_be[2]}}, {8{bus1.mem_be[1]}}, {8{bus1.mem_be[0]}}};
  assign bus1.mem_rd = dm[bus1.mem_addr[12:2]];
  assign bus3.mem_rd = dm[addr_d2[12:2]];

  always @(posedge Clock1) begin
    addr_d1 <= bus3.mem_addr;
    addr_d2 <= addr_d1;
    if (bus1.mem_be != 4'b0000) begin
      dm[bus1.mem_addr[12:2]] <= (dm[bus1.mem_addr[12:2]] & ~wmask) | (wshift & wmask);
      wr_count <= wr_count + 1;
      $display("  *%h <= %h (pc %h)", bus1.mem_addr, bus1.mem_wd, bus1.mem_wpc);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on the latency-1 unit; starts and ends at a negedge in IDLE.
  task automatic access1(input string tag, input logic wr, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic exc, input logic [4:0] code,
                         input logic [3:0] be, input logic [31:0] rdata);
    int wr0;
    wr0 = wr_count;
    check({tag, " ready"}, 32'(bus1.req_ready), 32'd1);
    bus1.req_valid = 1'b1;
    bus1.req_write = wr;
    bus1.req_type  = typ;
    bus1.req_addr  = addr;
    bus1.req_wdata = wdata;
    bus1.req_pc    = 32'h0000_3000 + addr;
    @(negedge Clock1);
    bus1.req_valid = 1'b0;
    if (!exc) begin
      check({tag, " be"}, 32'(bus1.mem_be), 32'(be));
      check({tag, " addr"}, bus1.mem_addr, addr);
      check({tag, " wpc"}, bus1.mem_wpc, 32'h0000_3000 + addr);
      check({tag, " early_resp"}, 32'(bus1.resp_valid), 32'd0);
      check({tag, " busy"}, 32'(bus1.req_ready), 32'd0);
      if (wr) check({tag, " wd"}, bus1.mem_wd, wdata);
      @(negedge Clock1);
    end
    check({tag, " resp_valid"}, 32'(bus1.resp_valid), 32'd1);
    check({tag, " exc"}, 32'(bus1.resp_exc), 32'(exc));
    check({tag, " code"}, 32'(bus1.resp_exc_code), 32'(code));
    check({tag, " rdata"}, bus1.resp_rdata, rdata);
    check({tag, " writes"}, 32'(wr_count - wr0), (wr && !exc) ? 32'd1 : 32'd0);
    @(negedge Clock1);
    check({tag, " resp_drop"}, 32'(bus1.resp_valid), 32'd0);
  endtask

  // Load on the latency-3 unit: response exactly four cycles after acceptance.
  task automatic access3(input string tag, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] rdata);
    check({tag, " ready"}, 32'(bus3.req_ready), 32'd1);
    bus3.req_valid = 1'b1;
    bus3.req_write = 1'b0;
    bus3.req_type  = typ;
    bus3.req_addr  = addr;
    bus3.req_pc    = 32'h0000_4000;
    for (int k = 1; k <= 3; k++) begin
      @(negedge Clock1);
      bus3.req_valid = 1'b0;
      check($sformatf("%s c%0d resp", tag, k), 32'(bus3.resp_valid), 32'd0);
      check($sformatf("%s c%0d ready", tag, k), 32'(bus3.req_ready), 32'd0);
      check($sformatf("%s c%0d addr", tag, k), bus3.mem_addr, addr);
      check($sformatf("%s c%0d be", tag, k), 32'(bus3.mem_be), 32'd0);
    end
    @(negedge Clock1);
    check({tag, " resp_valid"}, 32'(bus3.resp_valid), 32'd1);
    check({tag, " rdata"}, bus3.resp_rdata, rdata);
    check({tag, " exc"}, 32'(bus3.resp_exc), 32'd0);
    check({tag, " code"}, 32'(bus3.resp_exc_code), 32'd0);
    check({tag, " ready_resp"}, 32'(bus3.req_ready), 32'd0);
    @(negedge Clock1);
    check({tag, " ready_back"}, 32'(bus3.req_ready), 32'd1);
    check({tag, " resp_drop"}, 32'(bus3.resp_valid), 32'd0);
  endtask

  int wr_snap;

  initial begin
    Reset  = 1'b1;
    flush1 = 1'b0;
    flush3 = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_type = 3'd0;
    bus1.req_addr  = 32'h0; bus1.req_wdata = 32'h0; bus1.req_pc  = 32'h0;
    bus3.req_valid = 1'b0; bus3.req_write = 1'b0; bus3.req_type = 3'd0;
    bus3.req_addr  = 32'h0; bus3.req_wdata = 32'h0; bus3.req_pc  = 32'h0;
    repeat (3) @(negedge Clock1);

    check("rst ready", 32'(bus1.req_ready), 32'd1);
    check("rst resp_valid", 32'(bus1.resp_valid), 32'd0);
    check("rst mem_be", 32'(bus1.mem_be), 32'd0);
    check("rst mem_addr", bus1.mem_addr, 32'h0);
    check("rst mem_wd", bus1.mem_wd, 32'h0);
    check("rst mem_wpc", bus1.mem_wpc, 32'h0);
    check("rst rdata", bus1.resp_rdata, 32'h0);
    check("rst exc", 32'(bus1.resp_exc), 32'd0);
    check("rst ready3", 32'(bus3.req_ready), 32'd1);
    Reset = 1'b0;
    @(negedge Clock1);

    // word store/load
    access1("sw_10", 1'b1, MT_W, 32'h10, 32'hDEADBEEF, 1'b0, 5'd0, 4'hF, 32'h0);
    check("dm word4", dm[4], 32'hDEADBEEF);
    access1("lw_10", 1'b0, MT_W, 32'h10, 32'h0, 1'b0, 5'd0, 4'h0, 32'hDEADBEEF);

    // extraction from 0x80FF7F01
    access1("sw_00", 1'b1, MT_W, 32'h0, 32'h80FF7F01, 1'b0, 5'd0, 4'hF, 32'h0);
    access1("lb_2",  1'b0, MT_B,  32'h2, 32'h0, 1'b0, 5'd0, 4'h0, 32'hFFFFFFFF);
    access1("lbu_2", 1'b0, MT_BU, 32'h2, 32'h0, 1'b0, 5'd0, 4'h0, 32'h000000FF);
    access1("lb_0",  1'b0, MT_B,  32'h0, 32'h0, 1'b0, 5'd0, 4'h0, 32'h00000001);
    access1("lh_2",  1'b0, MT_H,  32'h2, 32'h0, 1'b0, 5'd0, 4'h0, 32'hFFFF80FF);
    access1("lhu_2", 1'b0, MT_HU, 32'h2, 32'h0, 1'b0, 5'd0, 4'h0, 32'h000080FF);
    access1("lb_3",  1'b0, MT_B,  32'h3, 32'h0, 1'b0, 5'd0, 4'h0, 32'hFFFFFF80);
    access1("lbu_1", 1'b0, MT_BU, 32'h1, 32'h0, 1'b0, 5'd0, 4'h0, 32'h0000007F);
    access1("lh_0",  1'b0, MT_H,  32'h0, 32'h0, 1'b0, 5'd0, 4'h0, 32'h00007F01);

    // sub-word stores into word 4 (DEADBEEF -> AAADBEEF -> 1234BEEF -> 123455EF)
    access1("sb_13", 1'b1, MT_B,  32'h13, 32'h000000AA, 1'b0, 5'd0, 4'b1000, 32'h0);
    access1("sh_12", 1'b1, MT_H,  32'h12, 32'h00001234, 1'b0, 5'd0, 4'b1100, 32'h0);
    access1("sb_11", 1'b1, MT_BU, 32'h11, 32'h00000055, 1'b0, 5'd0, 4'b0010, 32'h0);
    access1("lw_mix", 1'b0, MT_W, 32'h10, 32'h0, 1'b0, 5'd0, 4'h0, 32'h123455EF);

    // last legal word
    access1("sw_top", 1'b1, MT_W, 32'h1FFC, 32'h55AA55AA, 1'b0, 5'd0, 4'hF, 32'h0);
    access1("lw_top", 1'b0, MT_W, 32'h1FFC, 32'h0, 1'b0, 5'd0, 4'h0, 32'h55AA55AA);

    // exceptions
    access1("lw_mis",   1'b0, MT_W,  32'h6,    32'h0, 1'b1, EXC_ADEL, 4'h0, 32'h0);
    access1("sh_mis",   1'b1, MT_H,  32'h5,    32'h1, 1'b1, EXC_ADES, 4'h0, 32'h0);
    access1("lhu_mis",  1'b0, MT_HU, 32'h3,    32'h0, 1'b1, EXC_ADEL, 4'h0, 32'h0);
    access1("lw_range", 1'b0, MT_W,  32'h2000, 32'h0, 1'b1, EXC_ADEL, 4'h0, 32'h0);
    access1("sw_range", 1'b1, MT_W,  32'h2000, 32'h7, 1'b1, EXC_ADES, 4'h0, 32'h0);
    access1("st_rsvd",  1'b1, 3'b110, 32'h20,  32'h9, 1'b1, EXC_RI,   4'h0, 32'h0);
    access1("ld_rsvd",  1'b0, 3'b111, 32'h3,   32'h0, 1'b1, EXC_RI,   4'h0, 32'h0);

    // flush during ISSUE suppresses the store
    access1("sw_30", 1'b1, MT_W, 32'h30, 32'h11111111, 1'b0, 5'd0, 4'hF, 32'h0);
    wr_snap = wr_count;
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_type = MT_W;
    bus1.req_addr = 32'h30; bus1.req_wdata = 32'hCAFEF00D;
    @(negedge Clock1);
    bus1.req_valid = 1'b0;
    flush1 = 1'b1;
    #1;
    check("fl_issue be", 32'(bus1.mem_be), 32'd0);
    @(negedge Clock1);
    flush1 = 1'b0;
    #1;
    check("fl_issue ready", 32'(bus1.req_ready), 32'd1);
    check("fl_issue resp", 32'(bus1.resp_valid), 32'd0);
    @(negedge Clock1);
    check("fl_issue resp2", 32'(bus1.resp_valid), 32'd0);
    check("fl_issue writes", 32'(wr_count - wr_snap), 32'd0);
    access1("lw_30", 1'b0, MT_W, 32'h30, 32'h0, 1'b0, 5'd0, 4'h0, 32'h11111111);

    // flush in IDLE blocks acceptance
    wr_snap = wr_count;
    flush1 = 1'b1;
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_type = MT_W;
    bus1.req_addr = 32'h34; bus1.req_wdata = 32'h22222222;
    #1;
    check("fl_idle ready", 32'(bus1.req_ready), 32'd0);
    @(negedge Clock1);
    bus1.req_valid = 1'b0;
    flush1 = 1'b0;
    #1;
    check("fl_idle be", 32'(bus1.mem_be), 32'd0);
    check("fl_idle ready2", 32'(bus1.req_ready), 32'd1);
    @(negedge Clock1);
    check("fl_idle resp", 32'(bus1.resp_valid), 32'd0);
    check("fl_idle writes", 32'(wr_count - wr_snap), 32'd0);

    // flush in RESP kills the response pulse
    bus1.req_valid = 1'b1; bus1.req_write = 1'b0; bus1.req_type = MT_W; bus1.req_addr = 32'h30;
    @(negedge Clock1);
    bus1.req_valid = 1'b0;
    check("fl_resp addr", bus1.mem_addr, 32'h30);
    @(negedge Clock1);
    flush1 = 1'b1;
    #1;
    check("fl_resp valid", 32'(bus1.resp_valid), 32'd0);
    check("fl_resp rdata", bus1.resp_rdata, 32'h0);
    @(negedge Clock1);
    flush1 = 1'b0;
    #1;
    check("fl_resp ready", 32'(bus1.req_ready), 32'd1);
    check("fl_resp valid2", 32'(bus1.resp_valid), 32'd0);
    @(negedge Clock1);

    // Reset while a store is in ISSUE
    wr_snap = wr_count;
    bus1.req_valid = 1'b1; bus1.req_write = 1'b1; bus1.req_type = MT_W;
    bus1.req_addr = 32'h38; bus1.req_wdata = 32'h33333333;
    @(negedge Clock1);
    bus1.req_valid = 1'b0;
    Reset = 1'b1;
    #1;
    check("rst_issue be", 32'(bus1.mem_be), 32'd0);
    @(negedge Clock1);
    Reset = 1'b0;
    #1;
    check("rst_issue ready", 32'(bus1.req_ready), 32'd1);
    check("rst_issue addr", bus1.mem_addr, 32'h0);
    check("rst_issue writes", 32'(wr_count - wr_snap), 32'd0);
    @(negedge Clock1);
    check("rst_issue resp", 32'(bus1.resp_valid), 32'd0);

    // latency 3
    access3("l3_lw10", MT_W, 32'h10, 32'h123455EF);
    access3("l3_lb2",  MT_B, 32'h2,  32'hFFFFFFFF);

    // Reset during WAIT on the latency-3 unit
    bus3.req_valid = 1'b1; bus3.req_write = 1'b0; bus3.req_type = MT_W; bus3.req_addr = 32'h10;
    @(negedge Clock1);
    bus3.req_valid = 1'b0;
    @(negedge Clock1);
    check("rst_wait inwait addr", bus3.mem_addr, 32'h10);
    Reset = 1'b1;
    @(negedge Clock1);
    Reset = 1'b0;
    #1;
    check("rst_wait ready", 32'(bus3.req_ready), 32'd1);
    check("rst_wait addr", bus3.mem_addr, 32'h0);
    check("rst_wait be", 32'(bus3.mem_be), 32'd0);
    check("rst_wait resp", 32'(bus3.resp_valid), 32'd0);
    check("rst_wait rdata", bus3.resp_rdata, 32'h0);
    repeat (2) @(negedge Clock1);
    check("rst_wait late_resp", 32'(bus3.resp_valid), 32'd0);
    access3("l3_after_rst", MT_W, 32'h0, 32'h80FF7F01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory port: takes one load/store request at a time from the MEM pipeline stage and drives the DM word port (Addr / ByteEnable / WD / WPC).
- Collects the read word (RD), then returns an extracted, sign- or zero-extended load result, or an address exception.
- Performs all byte-enable generation, alignment/range checking and load extraction, so the memory stays a plain byte-enabled word array.
- Multi-state FSM with a configurable memory read latency, ready for block RAM on FPGA.

Parameters:
- DM_WORDS, 2048, number of 32-bit words in data memory; valid word index is 0..DM_WORDS-1.
- MEM_LATENCY, 1, cycles from address drive to valid mem_rd; legal range 1..8. 1 = combinational read.

Ports:
- Clock1  in  1  clock, all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- flush  in  1  kill the in-flight access (exception / eret in a later stage).
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_type  in  3  access type, per package codes.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned and unshifted.
- req_pc  in  32  PC of the instruction, forwarded for the write trace.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  extended load data; 0 for stores and exceptions.
- resp_exc  out  1  exception on this access.
- resp_exc_code  out  5  4 = AdEL, 5 = AdES, 10 = RI.
- mem_addr  out  32  to DM Addr.
- mem_be  out  4  to DM ByteEnable.
- mem_wd  out  32  to DM WD, unshifted; DM shifts by Addr[1:0].
- mem_wpc  out  32  to DM WPC.
- mem_rd  in  32  from DM RD, the full word.

Behaviour:
- Reset state: all outputs 0, except req_ready=1; FSM in IDLE; wait counter 0.
- Reset overrides everything, including a mid-access, and returns to IDLE. A store in ISSUE during Reset has mem_be=0.
- FSM states and transitions:
  - IDLE: req_ready = ~flush. On req_valid & req_ready, latch the request and check it:
    - Check fails: go to RESP with exception.
    - Check passes: go to ISSUE.
  - ISSUE (1 cycle): drive mem_addr = latched address and mem_wpc = latched PC.
    - Store: mem_be = BE pattern, mem_wd = latched wdata.
    - Load: mem_be = 0.
    - If MEM_LATENCY == 1, capture mem_rd at the end of this cycle and go to RESP; otherwise go to WAIT.
  - WAIT: mem_addr is held and mem_be = 0. Stay MEM_LATENCY-1 cycles, capture mem_rd in the last one, then go to RESP.
  - RESP (1 cycle): resp_valid = 1, then go to IDLE. req_ready = 0 in every state except IDLE.
- Latency: accept at cycle T -> resp_valid at T+MEM_LATENCY+1; back-to-back throughput is 1 access per MEM_LATENCY+2 cycles.
- Type codes:
  - 000: word (LW/SW).
  - 001: half, signed (LH/SH).
  - 010: half, unsigned (LHU; as a store, SH).
  - 011: byte, signed (LB/SB).
  - 100: byte, unsigned (LBU; as a store, SB).
  - 101-111: reserved -> exception code 10, no memory access.
- Checks, in priority order:
  1. Reserved type.
  2. Misalignment: half with addr[0]=1; word with addr[1:0]!=0.
  3. Range: addr[31:2] >= DM_WORDS.
  - Failure code: 4 for a load, 5 for a store. No ISSUE, mem_be never asserted.
- Byte-enable patterns:
  - Word: 1111.
  - Half: 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - Byte: 0001 << addr[1:0].
- Load extraction (combinational on the captured word, registered into resp_rdata):
  - Select the byte/half by addr[1:0].
  - Sign-extend for codes 001/011; zero-extend for 010/100.
- Flush:
  - In IDLE: blocks acceptance that cycle.
  - In ISSUE: mem_be is forced to 0 (store suppressed), go to IDLE.
  - In WAIT/RESP: go to IDLE with resp_valid = 0.
  - A flush coincident with Reset is covered by Reset.
- resp_rdata / resp_exc / resp_exc_code are held only while resp_valid; otherwise 0.

Decomposition:
- Package mem_access_pkg:
  - Type codes MT_W, MT_H, MT_HU, MT_B, MT_BU.
  - Exception codes EXC_ADEL=4, EXC_ADES=5, EXC_RI=10.
  - FSM state encoding IDLE / ISSUE / WAIT / RESP.
- Sub-module load_extend (combinational): inputs word, offset[1:0], type; output 32-bit extended data. Reused by a future cache.

Test Plan:
1. Store then load, word: SW addr 0x10, wdata 0xDEADBEEF.
   - mem_be=1111 for exactly one cycle, trace shows *00000010 <= deadbeef.
   - Then LW 0x10 -> resp_rdata 0xDEADBEEF at T+2 (MEM_LATENCY=1).
2. Byte/half extraction: memory word 0x80FF7F01.
   - LB 0x2 -> 0xFFFFFFFF; LBU 0x2 -> 0x000000FF; LB 0x0 -> 0x00000001.
   - LH 0x2 -> 0xFFFF80FF; LHU 0x2 -> 0x000080FF.
3. Sub-word stores: SB 0x13 with wdata 0x000000AA -> mem_be=1000, mem_wd=0x000000AA. SH 0x12 -> mem_be=1100.
4. Exceptions, each with mem_be stuck at 0 and resp_exc=1:
   - LW 0x6 -> code 4.
   - SH 0x5 -> code 5.
   - LW 0x2000 (DM_WORDS=2048) -> code 4.
   - Type 110 -> code 10.
5. Latency: MEM_LATENCY=3, LW accepted at T -> resp_valid only at T+4; req_ready=0 from T+1 to T+4, back to 1 at T+5.
6. Abort cases:
   - flush in the ISSUE cycle of SW -> mem_be=0, no memory change, no resp_valid.
   - Reset during WAIT -> IDLE next cycle, all outputs 0, req_ready=1.
